lif_neuron_array: RTL
=====================

# lif_neuron_array

Parametrised array of N_CH leaky integrate-and-fire neurons sharing one timestep strobe. This is the next generation of the single-neuron LIF block. Each channel integrates an unsigned synaptic current with shift-based leak, saturating accumulation, a runtime threshold and a true refractory counter. The block emits a registered spike vector plus a per-step spike population count, and sits between the synaptic input stage and spike routing/encoding logic.

## Interface
- WIDTH, 8: membrane and current width, in bits (≥4).
- N_CH, 4: number of neuron channels (≥1).
- LEAK_SHIFT, 2: leak is v >> LEAK_SHIFT per step (0 = full leak).
- REFRAC_CYCLES, 3: refractory length in timesteps after a spike (0 allowed).
- CNT_W, $clog2(N_CH+1): width of spike_cnt.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  timestep strobe; one neuron update per cycle it is high.
- isyn  in  N_CH*WIDTH  per-channel current; channel i at bits [i*WIDTH +: WIDTH].
- threshold  in  WIDTH  firing threshold, sampled on each in_valid cycle.
- clear  in  1  synchronous clear of all membrane and refractory state.
- spike  out  N_CH  per-channel spike for the completed step.
- out_valid  out  1  high for exactly one cycle per completed step.
- spike_cnt  out  CNT_W  number of 1s in spike for the completed step.
- refractory  out  N_CH  bit i high while channel i's refractory counter is non-zero.

## Operation
- Per-channel state:
  - v[i], WIDTH bits.
  - rc[i], a counter wide enough for REFRAC_CYCLES.
- Step, i.e. in_valid=1 and clear=0. Each channel i updates independently:
  - If rc[i]≠0:
    - rc[i] ← rc[i]−1 and v[i] ← 0.
    - spike[i]=0; isyn for that channel is ignored.
  - Else:
    - leaked = v[i] − (v[i] >> LEAK_SHIFT).
    - sum = leaked + isyn[i], computed at WIDTH+1 bits.
    - sat = min(sum, 2^WIDTH−1).
    - If sat ≥ threshold (unsigned): spike[i]=1, v[i] ← 0, rc[i] ← REFRAC_CYCLES.
    - Otherwise: spike[i]=0 and v[i] ← sat.
- No step (in_valid=0):
  - v and rc hold; there is no leak between steps.
  - spike, spike_cnt and out_valid return to 0.
- threshold=0: every non-refractory channel fires on every step.
- REFRAC_CYCLES=0: a channel that fires is eligible again on the very next step.
- clear=1:
  - All v and rc go to 0; spike, spike_cnt and out_valid go to 0.
  - clear overrides a simultaneous in_valid, and that step is discarded.
- spike_cnt = popcount of the spike vector written in the same cycle.
- refractory[i] = (rc[i]≠0), derived from the registered rc.

## Timing
- Reset (rst_n=0 at a rising edge): v, rc, spike, spike_cnt, out_valid and refractory all go to 0.
  - Reset has priority over clear and in_valid.
  - Reset mid-step discards that step.
- Latency: isyn and threshold sampled at edge k produce spike, spike_cnt and out_valid valid after edge k, i.e. during cycle k+1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Throughput: one step per cycle. Back-to-back in_valid keeps out_valid high continuously.
- A fired channel spends exactly REFRAC_CYCLES steps (counted as in_valid pulses, not clock cycles) with spike=0. It integrates again on step REFRAC_CYCLES+1 after the spike, starting from v=0.

## Test plan
All scenarios use WIDTH=8, N_CH=4, LEAK_SHIFT=2, REFRAC_CYCLES=3 unless stated.
- Reset: hold rst_n=0 with in_valid=1, isyn all 8'hFF -> spike=0, spike_cnt=0, out_valid=0, refractory=0; after release, first step output appears one cycle later.
- Integration and leak: threshold=100, ch0 isyn=40 every cycle -> v sequence 40, 70, 93; fires on 4th step (sum 110), spike=4'b0001, spike_cnt=1.
- Refractory: continue the previous scenario -> steps 5–7 give spike[0]=0 with refractory[0]=1; step 8 gives refractory[0]=0 and v=40; next spike on step 11.
- Saturation: threshold=255, isyn=200 -> step 1 v=200; step 2 sum 350 saturates to 255 and fires (no wrap to 94).
- Simultaneous events: all channels isyn=8'hFF, threshold=10 -> spike=4'hF, spike_cnt=4. Then assert clear together with in_valid -> out_valid=0, all state 0, refractory=0.
- Idle gaps: ch1 at v=70, in_valid low 10 cycles -> no out_valid, v holds 70. Next step with isyn=0 -> v=53, spike=0.

Source files
------------

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons that share one timestep strobe.
// Each channel has its own membrane register and refractory counter. The
// spike vector, its population count and out_valid are all registered.
module lif_neuron_array #(
    parameter int WIDTH         = 8,
    parameter int N_CH          = 4,
    parameter int LEAK_SHIFT    = 2,
    parameter int REFRAC_CYCLES = 3,
    parameter int CNT_W         = $clog2(N_CH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [N_CH*WIDTH-1:0]   isyn,
    input  logic [WIDTH-1:0]        threshold,
    input  logic                    clear,
    output logic [N_CH-1:0]         spike,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        spike_cnt,
    output logic [N_CH-1:0]         refractory
);

    // The counter keeps at least one bit so REFRAC_CYCLES=0 still elaborates.
    localparam int RC_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRAC_CYCLES);

    // Spike decisions for the step being taken in this cycle.
    logic [N_CH-1:0]  spike_d;
    logic [CNT_W-1:0] cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] v_q, v_d;
            logic [RC_W-1:0]  rc_q, rc_d;
            logic [WIDTH-1:0] leaked;
            logic [WIDTH:0]   sum;
            logic [WIDTH-1:0] sat;
            logic             fire;

            // Leak, integrate with saturation, then decide fire / refractory.
            always_comb begin
                leaked = v_q - (v_q >> LEAK_SHIFT);
                sum    = {1'b0, leaked} + {1'b0, isyn[gi*WIDTH +: WIDTH]};
                sat    = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                v_d    = v_q;
                rc_d   = rc_q;
                fire   = 1'b0;
                if (in_valid) begin
                    if (rc_q != '0) begin
                        // Refractory: the current input is ignored.
                        rc_d = rc_q - 1'b1;
                        v_d  = '0;
                    end else if (sat >= threshold) begin
                        fire = 1'b1;
                        v_d  = '0;
                        rc_d = RC_LOAD;
                    end else begin
                        v_d = sat;
                    end
                end
            end

            // Membrane and refractory state; clear discards any coincident step.
            always_ff @(posedge clk) begin
                if (!rst_n || clear) begin
                    v_q  <= '0;
                    rc_q <= '0;
                end else begin
                    v_q  <= v_d;
                    rc_q <= rc_d;
                end
            end

            assign spike_d[gi]    = fire;
            assign refractory[gi] = (rc_q != '0);
        end
    endgenerate

    // Population count of the spikes produced by this step.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d = cnt_d + CNT_W'(spike_d[i]);
        end
    end

    // Registered step outputs; they drop to zero on idle cycles.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            spike     <= '0;
            out_valid <= 1'b0;
            spike_cnt <= '0;
        end else begin
            spike     <= spike_d;
            out_valid <= in_valid;
            spike_cnt <= cnt_d;
        end
    end

endmodule
